// File: rtl/shared_delay_scheduler_if.sv
// rtl/shared_delay_scheduler_if.sv - request/grant bundle between requesters and the shared delay timer
// Purpose: groups the requester-side signals of shared_delay_scheduler.
// Signals:
//   REQ   [NUM_REQ]          level request per requester
//   DELAY [NUM_REQ*DELAY_W]  requested tick count, slice i = DELAY[i*DELAY_W +: DELAY_W]
//   GNT   [NUM_REQ]          one-hot timer owner, zero when idle
//   DONE  [NUM_REQ]          one-cycle completion pulse to the owner
//   BUSY                     scheduler not idle
//   TICK                     one-cycle prescaler tick while a delay runs
// Modports: master (requester side), slave (scheduler side).
interface shared_delay_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DELAY_W = 8
);
  logic [NUM_REQ-1:0]         REQ;
  logic [NUM_REQ*DELAY_W-1:0] DELAY;
  logic [NUM_REQ-1:0]         GNT;
  logic [NUM_REQ-1:0]         DONE;
  logic                       BUSY;
  logic                       TICK;

  modport master (output REQ, DELAY, input GNT, DONE, BUSY, TICK);
  modport slave  (input REQ, DELAY, output GNT, DONE, BUSY, TICK);
endinterface

// File: rtl/shared_delay_scheduler.sv
// rtl/shared_delay_scheduler.sv - round-robin time-sharing of one prescaled delay timer
// Purpose: grants a single divide-by-PRESCALE tick counter to NUM_REQ requesters in
//   round-robin order, counts the latched DELAY ticks and pulses DONE to the owner.
// Ports:
//   CLK_IN  system clock, rising edge
//   RST     asynchronous active-high reset
//   bus     shared_delay_scheduler_if.slave (REQ, DELAY in; GNT, DONE, BUSY, TICK out)
// Option: SHARED_DELAY_SCHEDULER_ABORT_EN - owner dropping REQ during RUN aborts the
//   delay without a DONE pulse. Undefined: REQ is ignored once granted.
module shared_delay_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int DELAY_W  = 8,
  parameter int PRESCALE = 50
) (
  input logic                      CLK_IN,
  input logic                      RST,
  shared_delay_scheduler_if.slave  bus
);
  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [PW-1:0] PRE_RELOAD = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 tick_q, tick_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [DELAY_W-1:0]   rem_q, rem_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        owner_q, owner_d;

  logic                 sel_valid;
  logic [IW-1:0]        sel;
  logic [DELAY_W-1:0]   sel_delay;
  logic [IW-1:0]        next_ptr;

  // Search from the pointer upward with wrap; iterating from the far end lets
  // the nearest set bit win.
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.REQ[(int'(ptr_q) + k) % NUM_REQ]) begin
        sel_valid = 1'b1;
        sel       = IW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign sel_delay = bus.DELAY[int'(sel) * DELAY_W +: DELAY_W];
  assign next_ptr  = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    presc_d = presc_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          gnt_d   = NUM_REQ'(1) << sel;
          owner_d = sel;
          rem_d   = sel_delay;
          presc_d = PRE_RELOAD;
          if (sel_delay != '0) begin
            state_d = RUN;
          end else begin
            state_d = FIN;
            done_d  = NUM_REQ'(1) << sel;
          end
        end
      end
      RUN: begin
`ifdef SHARED_DELAY_SCHEDULER_ABORT_EN
        if (!bus.REQ[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr;
        end else
`endif
        if (presc_q == '0) begin
          presc_d = PRE_RELOAD;
          // The last tick goes straight to FIN so remaining never drops below 1.
          if (rem_q == DELAY_W'(1)) begin
            state_d = FIN;
            done_d  = gnt_q;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end else begin
          presc_d = presc_q - 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = next_ptr;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    // Registered tick: high in the cycle where the running prescaler sits at zero.
    tick_d = (state_d == RUN) && (presc_d == '0);
  end

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      tick_q  <= 1'b0;
      presc_q <= '0;
      rem_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign bus.GNT  = gnt_q;
  assign bus.DONE = done_q;
  assign bus.TICK = tick_q;
  assign bus.BUSY = (state_q != IDLE);
endmodule

// File: tb/tb_shared_delay_scheduler.sv
// tb/tb_shared_delay_scheduler.sv - scoreboard bench for shared_delay_scheduler
module tb_shared_delay_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int P = 4;

  typedef struct {
    int owner;
    int gnt_cyc;
    int done_cyc;
    int delay;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shared_delay_scheduler_if #(.NUM_REQ(N), .DELAY_W(W)) bus ();

  shared_delay_scheduler #(.NUM_REQ(N), .DELAY_W(W), .PRESCALE(P)) dut (
    .CLK_IN (clk),
    .RST    (rst),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sbq[$];
  exp_t e;
  int   mptr = 0;
  int   dly[N];

  bit             mon_en = 1'b0;
  int             g_start = 0;
  int             tick_cnt = 0;
  logic [N-1:0]   prev_gnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: observes the DUT and pops the scoreboard at every DONE pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy_vs_gnt", bus.BUSY, |bus.GNT);
      if (bus.GNT != '0 && prev_gnt == '0) begin
        g_start  = cyc;
        tick_cnt = 0;
        chk("gnt_onehot", $onehot(bus.GNT), 1);
      end
      if (bus.TICK) begin
        tick_cnt++;
        chk("tick_in_grant", |bus.GNT, 1);
        chk("tick_phase", (cyc - g_start + 1) % P, 0);
      end
      if (bus.DONE != '0) begin
        if (sbq.size() == 0) begin
          chk("done_unexpected", bus.DONE, 0);
        end else begin
          e = sbq.pop_front();
          chk("done_owner", bus.DONE, 1 << e.owner);
          chk("done_with_gnt", bus.GNT, 1 << e.owner);
          chk("done_cycle", cyc, e.done_cyc);
          chk("gnt_start_cycle", g_start, e.gnt_cyc);
          chk("tick_count", tick_cnt, e.delay);
        end
      end
      prev_gnt = bus.GNT;
    end
  end

  // Applies REQ=mask with delays dly[] while the DUT is idle, predicts the grant
  // sequence, then drops each REQ bit in its DONE cycle until all are served.
  task automatic run_round(input logic [N-1:0] mask);
    logic [N-1:0] m;
    logic [N-1:0] pg;
    int c, o, budget;
    bit found, fin;
    for (int i = 0; i < N; i++) bus.DELAY[i*W +: W] = dly[i][W-1:0];
    bus.REQ = mask;
    m = mask;
    c = cyc + 1;
    while (m != '0) begin
      found = 1'b0;
      o = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && m[(mptr + k) % N]) begin
          found = 1'b1;
          o = (mptr + k) % N;
        end
      end
      sbq.push_back('{owner: o, gnt_cyc: c, done_cyc: c + dly[o] * P, delay: dly[o]});
      m[o] = 1'b0;
      mptr = (o + 1) % N;
      c = c + dly[o] * P + 2;
    end
    pg = '0;
    fin = 1'b0;
    budget = 0;
    while (!fin && budget < 3000) begin
      @(negedge clk);
      budget++;
      // Changing the owner's DELAY after the grant must not affect its timing.
      if (bus.GNT != '0 && pg == '0) begin
        for (int i = 0; i < N; i++)
          if (bus.GNT[i]) bus.DELAY[i*W +: W] = W'($urandom_range(50, 255));
      end
      pg = bus.GNT;
      bus.REQ = bus.REQ & ~bus.DONE;
      if (bus.REQ == '0 && bus.GNT == '0 && sbq.size() == 0) fin = 1'b1;
    end
    if (!fin) chk("round_timeout", 1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] rm;
    bus.REQ   = '0;
    bus.DELAY = '0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", bus.GNT, 0);
    chk("reset_done", bus.DONE, 0);
    chk("reset_busy", bus.BUSY, 0);
    chk("reset_tick", bus.TICK, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_req_gnt", bus.GNT, 0);

    // Single request: REQ[2], DELAY=3.
    dly = '{0, 0, 3, 0};
    run_round(4'b0100);
    // Round robin, all DELAY=1.
    dly = '{1, 1, 1, 1};
    run_round(4'b1111);
    dly = '{1, 0, 0, 0};
    run_round(4'b0001);
    // Zero delay on REQ[1].
    dly = '{0, 0, 0, 0};
    run_round(4'b0010);

    // Randomized rounds.
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 4);
      rm = N'($urandom_range(1, (1 << N) - 1));
      run_round(rm);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of a DELAY=10 grant.
    mon_en = 1'b0;
    bus.DELAY[0 +: W] = W'(10);
    bus.REQ = 4'b0001;
    for (int t = 0; t < 20 && bus.GNT == '0; t++) @(negedge clk);
    chk("pre_reset_gnt", bus.GNT, 1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_gnt", bus.GNT, 0);
    chk("async_reset_tick", bus.TICK, 0);
    chk("async_reset_busy", bus.BUSY, 0);
    bus.REQ = '0;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    prev_gnt = '0;
    mptr = 0;
    mon_en = 1'b1;
    @(negedge clk);
    dly = '{0, 0, 0, 2};
    run_round(4'b1000);
    dly = '{0, 2, 0, 1};
    run_round(4'b1010);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shared_delay_scheduler.md
Name: shared_delay_scheduler

Overview:
- Time-shares one prescaled delay timer (divide-by-PRESCALE tick generator plus tick down-counter) among NUM_REQ requesters.
- Each requester asks for a wait of DELAY ticks. The block grants the timer round-robin, counts the delay, and returns a one-cycle DONE pulse to the owner.
- Sits beside the divide-by-N clock dividers. It gives slow-rate sequencing without instantiating one divider per consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DELAY_W, 8, width of each requested delay in ticks
- PRESCALE, 50, CLK_IN cycles per tick (>=2)

Ports:
- CLK_IN  input  1  system clock, all logic on rising edge
- RST  input  1  asynchronous, active-high reset
- REQ  input  NUM_REQ  level request per requester
- DELAY  input  NUM_REQ*DELAY_W  requested tick count; slice i = DELAY[i*DELAY_W +: DELAY_W]
- GNT  output  NUM_REQ  one-hot owner of the timer, all-zero when idle
- DONE  output  NUM_REQ  one-cycle completion pulse to owner
- BUSY  output  1  high whenever state != IDLE
- TICK  output  1  one-cycle prescaler tick, only during RUN

Behaviour:
- Reset (asynchronous, any time, including mid-delay):
  - state=IDLE; GNT=0, DONE=0, BUSY=0, TICK=0.
  - Prescaler=0, remaining=0, round-robin pointer=0 (REQ[0] highest priority first).
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - If REQ != 0, select the first set bit searching upward from the pointer, with wrap-around.
  - Next edge: GNT=onehot(sel); latch DELAY slice into remaining; load prescaler with PRESCALE-1.
  - Go to RUN if the latched delay != 0, else go to FIN.
  - With no requests, stay in IDLE; outputs stay 0.
- RUN:
  - Prescaler counts down each cycle. At 0: TICK=1 that cycle, prescaler reloads PRESCALE-1, remaining decrements.
  - A tick with remaining==1 moves the FSM to FIN.
  - RUN lasts exactly DELAY*PRESCALE cycles.
  - REQ changes are ignored; the latched DELAY is used, so later DELAY input changes have no effect.
- FIN (one cycle):
  - DONE[owner]=1 and GNT still asserted.
  - Next edge: GNT=0, DONE=0, pointer=owner+1 (mod NUM_REQ), go to IDLE.
- Latency:
  - REQ sampled high in IDLE -> GNT high on the next cycle.
  - GNT stays high for DELAY*PRESCALE+1 cycles; DONE is the last of these.
  - DELAY=0 -> GNT and DONE are high together for one cycle.
- Back-to-back:
  - There is one IDLE cycle between a FIN and the next grant.
  - A requester must drop REQ in its DONE cycle. A REQ still high in IDLE is a new request and competes at the lowest priority, since the pointer has moved past it.
- Widths:
  - remaining is DELAY_W bits.
  - Prescaler width is clog2(PRESCALE).
  - No wrap: remaining never decrements below 1 in RUN.
- DONE, GNT and TICK are registered outputs; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SHARED_DELAY_SCHEDULER_ABORT_EN.
- Defined: REQ[owner] low during RUN aborts the delay.
  - Next edge: GNT=0, TICK=0, state=IDLE, pointer=owner+1; no DONE pulse.
  - Abort is not checked in FIN; DONE still fires.
- Undefined: REQ is ignored during RUN/FIN; every grant ends with a DONE pulse.

Test Plan:
- Single request, PRESCALE=4: REQ[2]=1, DELAY[2]=3 -> GNT=0100 one cycle later; TICK pulses every 4 cycles (3 pulses); DONE[2] in cycle 13 of GNT; BUSY low the cycle after.
- Round-robin: REQ=1111 held, all DELAY=1, PRESCALE=4 -> grant order 0,1,2,3,0; each GNT lasts 5 cycles; one idle cycle between grants.
- DELAY=0 on REQ[1] -> GNT[1] and DONE[1] are high for the same single cycle; TICK is never asserted.
- Reset mid-RUN: assert RST 5 cycles into a DELAY=10 grant -> GNT, TICK, BUSY drop to 0 asynchronously; after release, REQ[3] alone is granted with a full PRESCALE before the first TICK.
- DELAY change during RUN: grant REQ[0] with DELAY=2, then change DELAY[0] to 200 -> DONE[0] still arrives after 2*PRESCALE+1 cycles.
- ABORT_EN defined: REQ[1] drops mid-RUN -> GNT=0 next cycle, no DONE[1]; a pending REQ[2] is granted one cycle later. Undefined: the same stimulus yields DONE[1] at the normal time.
